// File: rtl/stack_spill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_spill_ctrl
// Description : Spill/fill controller for a small on-chip hardware stack.
//               Core push/pop/replace requests are forwarded to the on-chip
//               stack. When that stack is full, the deepest element is written
//               out to a spill memory before a push is accepted. When it is
//               empty, the most recently spilled element is read back before a
//               pop or replace is accepted.
// Ports       : clk, reset_n             clock, async active-low reset
//               core_push/pop/data/ready core request handshake
//               stk_push/pop/insert      commands to the on-chip stack
//               stk_bottom               deepest on-chip element
//               mem_req/we/addr/wdata    spill memory request
//               mem_rdata/ack            spill memory response
//               count, spilled           on-chip and in-memory occupancy
//               overflow, underflow      sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module stack_spill_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          core_push,
    input  logic                          core_pop,
    input  logic [WIDTH-1:0]              core_data,
    output logic                          core_ready,
    output logic                          stk_push,
    output logic                          stk_pop,
    output logic [WIDTH-1:0]              stk_insert,
    input  logic [WIDTH-1:0]              stk_bottom,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic [WIDTH-1:0]              mem_rdata,
    input  logic                          mem_ack,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [ADDR_WIDTH:0]           spilled,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPILL = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    localparam logic [CNT_W-1:0]      CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEPTH-1);
    localparam logic [ADDR_WIDTH:0]   SPL_ZERO  = '0;
    localparam logic [ADDR_WIDTH:0]   SPL_ONE   = (ADDR_WIDTH+1)'(1);
    // Spill capacity 2**ADDR_WIDTH, one extra bit so "completely full" fits.
    localparam logic [ADDR_WIDTH:0]   SPL_CAP   = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic [CNT_W-1:0]       count_nxt;
    logic [ADDR_WIDTH:0]    spilled_nxt;
    logic                   overflow_set;
    logic                   underflow_set;

    logic push_only;
    logic pop_only;
    logic replace;
    logic onchip_full;
    logic onchip_empty;
    logic mem_full;
    logic mem_empty;

    assign push_only    = core_push & ~core_pop;
    assign pop_only     = core_pop & ~core_push;
    assign replace      = core_push & core_pop;
    assign onchip_full  = (count == CNT_FULL);
    assign onchip_empty = (count == CNT_ZERO);
    assign mem_full     = (spilled == SPL_CAP);
    assign mem_empty    = (spilled == SPL_ZERO);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy counters and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= CNT_ZERO;
            spilled   <= SPL_ZERO;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count   <= count_nxt;
            spilled <= spilled_nxt;
            if (overflow_set) begin
                overflow <= 1'b1;
            end
            if (underflow_set) begin
                underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (push_only && onchip_full && !mem_full) begin
                    next_state = ST_SPILL;
                end else if ((pop_only || replace) && onchip_empty && !mem_empty) begin
                    next_state = ST_FILL;
                end
            end
            ST_SPILL: begin
                if (mem_ack) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and counter-update logic
    // ------------------------------------------------------------------
    always_comb begin
        core_ready    = 1'b0;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_insert    = core_data;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        count_nxt     = count;
        spilled_nxt   = spilled;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;

        case (state)
            ST_IDLE: begin
                if (push_only) begin
                    if (!onchip_full) begin
                        core_ready = 1'b1;
                        stk_push   = 1'b1;
                        count_nxt  = count + CNT_ONE;
                    end else if (mem_full) begin
                        // Nowhere to spill: the stack itself drops its
                        // bottom element on a push while full.
                        core_ready   = 1'b1;
                        stk_push     = 1'b1;
                        overflow_set = 1'b1;
                    end
                end else if (pop_only) begin
                    if (!onchip_empty) begin
                        core_ready = 1'b1;
                        stk_pop    = 1'b1;
                        count_nxt  = count - CNT_ONE;
                    end else if (mem_empty) begin
                        core_ready    = 1'b1;
                        underflow_set = 1'b1;
                    end
                end else if (replace) begin
                    if (!onchip_empty) begin
                        core_ready = 1'b1;
                        stk_push   = 1'b1;
                        stk_pop    = 1'b1;
                    end else if (mem_empty) begin
                        // Replacing on a totally empty stack degenerates to a push.
                        core_ready = 1'b1;
                        stk_push   = 1'b1;
                        count_nxt  = CNT_ONE;
                    end
                end
            end
            ST_SPILL: begin
                // spilled and the stack are frozen here, so these stay stable.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = spilled[ADDR_WIDTH-1:0];
                mem_wdata = stk_bottom;
                if (mem_ack) begin
                    count_nxt   = CNT_LAST;
                    spilled_nxt = spilled + SPL_ONE;
                end
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_WIDTH'(spilled - SPL_ONE);
                if (mem_ack) begin
                    stk_push    = 1'b1;
                    stk_insert  = mem_rdata;
                    count_nxt   = CNT_ONE;
                    spilled_nxt = spilled - SPL_ONE;
                end
            end
            default: begin
                core_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
